// File: rtl/fir_l3_input_packer_if.sv
// Handshake bundle between a serial sample source, the L=3 input packer and the
// block consumer. The slave modport is the packer's view; master is the environment's view.
interface fir_l3_input_packer_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic [W-1:0]     x3;
    logic [1:0]       out_cnt;
    logic             out_last;
    logic [CNT_W-1:0] frame_samples;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, x1, x2, x3, out_cnt, out_last, frame_samples
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, x1, x2, x3, out_cnt, out_last, frame_samples
    );
endinterface

// File: rtl/fir_l3_input_packer.sv
// Packs a serial valid/ready sample stream into 3-sample blocks for the L=3 parallel FIR,
// zero-padding a frame's trailing partial block and flagging frame ends.
module fir_l3_input_packer #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    fir_l3_input_packer_if.slave bus
);
    typedef enum logic [1:0] {
        StPh0 = 2'd0,
        StPh1 = 2'd1,
        StPh2 = 2'd2
    } phase_e;

    phase_e           phase_q, phase_d;
    logic [W-1:0]     s0_q, s0_d;
    logic [W-1:0]     s1_q, s1_d;
    logic [W-1:0]     x1_q, x1_d;
    logic [W-1:0]     x2_q, x2_d;
    logic [W-1:0]     x3_q, x3_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    logic out_free;
    logic would_complete;
    logic in_ready;
    logic accept;
    logic complete;

    // Only a completing sample needs the output register, so only it can be stalled.
    always_comb begin
        out_free       = !valid_q || bus.out_ready;
        would_complete = (phase_q == StPh2) || bus.in_last;
        in_ready       = out_free || !would_complete;
        accept         = bus.in_valid && in_ready;
        complete       = accept && would_complete;
    end

    always_comb begin
        phase_d = phase_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;

        if (accept && !would_complete) begin
            unique case (phase_q)
                StPh0: begin
                    s0_d    = bus.in_data;
                    phase_d = StPh1;
                end
                StPh1: begin
                    s1_d    = bus.in_data;
                    phase_d = StPh2;
                end
                default: ;
            endcase
        end

        if (complete) begin
            phase_d = StPh0;
            valid_d = 1'b1;
            last_d  = bus.in_last;
            unique case (phase_q)
                StPh0: begin
                    x1_d  = bus.in_data;
                    x2_d  = '0;
                    x3_d  = '0;
                    cnt_d = 2'd1;
                end
                StPh1: begin
                    x1_d  = s0_q;
                    x2_d  = bus.in_data;
                    x3_d  = '0;
                    cnt_d = 2'd2;
                end
                StPh2: begin
                    x1_d  = s0_q;
                    x2_d  = s1_q;
                    x3_d  = bus.in_data;
                    cnt_d = 2'd3;
                end
                default: ;
            endcase
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (bus.in_last) begin
                fcnt_d = '0;
            end else if (fcnt_q != '1) begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= StPh0;
            s0_q    <= '0;
            s1_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.x1            = x1_q;
    assign bus.x2            = x2_q;
    assign bus.x3            = x3_q;
    assign bus.out_cnt       = cnt_q;
    assign bus.out_last      = last_q;
    assign bus.frame_samples = fcnt_q;
endmodule
